// File: rtl/proc_pkg.sv
// proc_pkg: opcode constants, instruction field ranges and issue FSM states shared by the issue block.
package proc_pkg;
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 24;
    localparam int DST_HI = 23;
    localparam int DST_LO = 16;
    localparam int OP1_HI = 15;
    localparam int OP1_LO = 8;
    localparam int OP2_HI = 7;
    localparam int OP2_LO = 0;
    localparam logic [7:0] OP_AND  = 8'd0;
    localparam logic [7:0] OP_ADD  = 8'd1;
    localparam logic [7:0] OP_DISP = 8'd2;
    localparam logic [7:0] OP_RSV  = 8'd3;
    typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_CAPTURE, ST_FINISH} state_t;
    function automatic logic is_legal(input logic [7:0] op);
        return op <= OP_RSV;
    endfunction
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: DEPTH x W instruction queue with wrapping pointers and an occupancy counter.
module instr_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_data,
    output logic [W-1:0]               o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0] r_cnt;
    logic w_push, w_pop;
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_count = r_cnt;
    assign o_data  = r_mem[r_rp];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/instr_issue.sv
// instr_issue: queues instructions, issues them one at a time to a fixed-latency proc and captures results.
module instr_issue
    import proc_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int RES_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [31:0] load_instr,
    output logic        load_full,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic [8:0]  res_in,
    output logic [8:0]  res_out,
    output logic [7:0]  res_tag,
    output logic        res_valid,
    output logic        err,
    output logic [7:0]  issued_count
);
    localparam int OW = $clog2(DEPTH) + 1;
    state_t r_state, w_next;
    logic [2:0] r_wcnt;
    logic [31:0] r_instr;
    logic r_instr_valid, r_err;
    logic [8:0] r_res_out;
    logic [7:0] r_res_tag, r_count;
    logic [31:0] w_head;
    logic [OW-1:0] w_occ;
    logic w_full, w_empty, w_legal, w_issue, w_capture, w_more;

    instr_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (load_en && !load_full),
        .i_pop   (w_issue),
        .i_data  (load_instr),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_occ)
    );

    assign w_issue   = r_state == ST_ISSUE;
    assign w_capture = r_state == ST_CAPTURE;
    assign w_legal   = is_legal(w_head[OPC_HI:OPC_LO]);
    // occupancy still counts the head being popped this cycle
    assign w_more    = w_occ > OW'(1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    w_next = start ? (w_empty ? ST_FINISH : ST_ISSUE) : ST_IDLE;
            ST_ISSUE:   w_next = w_legal ? ST_WAIT : (w_more ? ST_ISSUE : ST_FINISH);
            ST_WAIT:    w_next = (r_wcnt == 3'(RES_LAT - 1)) ? ST_CAPTURE : ST_WAIT;
            ST_CAPTURE: w_next = w_empty ? ST_FINISH : ST_ISSUE;
            ST_FINISH:  w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_wcnt        <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_err         <= 1'b0;
            r_res_out     <= '0;
            r_res_tag     <= '0;
            r_count       <= '0;
        end else begin
            r_state       <= w_next;
            r_wcnt        <= (r_state == ST_WAIT) ? r_wcnt + 3'd1 : 3'd0;
            r_instr_valid <= w_issue && w_legal;
            r_err         <= w_issue && !w_legal;
            if (w_issue && w_legal) r_instr <= w_head;
            if (r_state == ST_IDLE && start) r_count <= '0;
            if (w_capture) begin
                r_res_out <= res_in;
                r_res_tag <= r_instr[DST_HI:DST_LO];
                r_count   <= r_count + 8'd1;
            end
        end
    end

    // the result is presented in the cycle it arrives and then held
    assign res_valid    = w_capture;
    assign res_out      = w_capture ? res_in : r_res_out;
    assign res_tag      = w_capture ? r_instr[DST_HI:DST_LO] : r_res_tag;
    assign instr        = r_instr;
    assign instr_valid  = r_instr_valid;
    assign err          = r_err;
    assign busy         = r_state != ST_IDLE;
    assign done         = r_state == ST_FINISH;
    assign load_full    = w_full || busy;
    assign issued_count = r_count;
endmodule

// File: tb/tb_instr_issue.sv
// tb_instr_issue: directed and random issue sequences checked against a timeline model of the issue rules.
module tb_instr_issue;
    localparam int DEPTH = 8;
    localparam int LAT   = 3;
    logic clk = 1'b0;
    logic rst, load_en, start;
    logic [31:0] load_instr, instr;
    logic load_full, busy, done, instr_valid, res_valid, err;
    logic [8:0] res_in, res_out;
    logic [7:0] res_tag, issued_count;

    instr_issue #(.DEPTH(DEPTH), .RES_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_instr(load_instr), .load_full(load_full),
        .start(start), .busy(busy), .done(done), .instr(instr), .instr_valid(instr_valid),
        .res_in(res_in), .res_out(res_out), .res_tag(res_tag), .res_valid(res_valid),
        .err(err), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] w; int c;} iv_t;
    typedef struct {logic [7:0] tag; logic [8:0] out; int c; logic [31:0] ins;} rs_t;
    typedef struct {int c; logic [8:0] v;} pd_t;
    iv_t ivq[$];
    rs_t rsq[$];
    pd_t pq[$];
    int cyc = 0, n_cmp = 0, n_err = 0;
    int n_errp, n_done, n_busy, done_c, first_busy;

    function automatic logic [8:0] ref_res(input logic [31:0] w);
        case (w[31:24])
            8'd0:    return {1'b0, w[15:8] & w[7:0]};
            8'd1:    return 9'(w[15:8]) + 9'(w[7:0]);
            8'd2:    return {1'b0, w[15:8]};
            default: return {1'b1, w[7:0]};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        ivq.delete(); rsq.delete(); pq.delete();
        n_errp = 0; n_done = 0; n_busy = 0; done_c = -1; first_busy = -1;
    endtask

    // advance one cycle: play the proc result due this cycle, then log the outputs
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (pq.size() > 0 && pq[0].c == cyc) begin
            res_in = pq[0].v;
            void'(pq.pop_front());
        end else res_in = 9'($urandom);
        #1;
        if (instr_valid === 1'b1) begin
            ivq.push_back('{instr, cyc});
            pq.push_back('{cyc + LAT, ref_res(instr)});
        end
        if (res_valid === 1'b1) rsq.push_back('{res_tag, res_out, cyc, instr});
        if (err === 1'b1) n_errp++;
        if (done === 1'b1) begin n_done++; done_c = cyc; end
        if (busy === 1'b1) begin n_busy++; if (first_busy < 0) first_busy = cyc; end
    endtask

    task automatic load_words(input logic [31:0] ws[$], inout logic [31:0] qm[$]);
        foreach (ws[i]) begin
            load_en = 1'b1;
            load_instr = ws[i];
            chk("load_full", 32'(load_full), 32'(qm.size() == DEPTH));
            if (qm.size() < DEPTH) qm.push_back(ws[i]);
            step();
        end
        load_en = 1'b0;
    endtask

    task automatic run_seq(input logic [31:0] ws[$]);
        logic [31:0] qm[$];
        logic [31:0] lw[$];
        int ivc[$];
        int s, t;
        clear_logs();
        load_words(ws, qm);
        start = 1'b1;
        s = cyc;
        step();
        start = 1'b0;
        t = s + 1;
        foreach (qm[i]) begin
            if (qm[i][31:24] <= 8'd3) begin
                lw.push_back(qm[i]);
                ivc.push_back(t + 1);
                t += LAT + 2;
            end else t += 1;
        end
        for (int k = 0; k < 500 && n_done == 0; k++) step();
        chk("done_seen", 32'(n_done > 0), 32'd1);
        repeat (3) step();
        chk("done_count", 32'(n_done), 32'd1);
        chk("done_cycle", 32'(done_c), 32'(t));
        chk("busy_first", 32'(first_busy), 32'(s + 1));
        chk("busy_cycles", 32'(n_busy), 32'(t - s));
        chk("iv_count", 32'(ivq.size()), 32'(lw.size()));
        chk("res_count", 32'(rsq.size()), 32'(lw.size()));
        for (int i = 0; i < lw.size() && i < ivq.size(); i++) begin
            chk("iv_word", ivq[i].w, lw[i]);
            chk("iv_cycle", 32'(ivq[i].c), 32'(ivc[i]));
        end
        for (int i = 0; i < lw.size() && i < rsq.size(); i++) begin
            chk("res_tag", 32'(rsq[i].tag), 32'(lw[i][23:16]));
            chk("res_out", 32'(rsq[i].out), 32'(ref_res(lw[i])));
            chk("res_cycle", 32'(rsq[i].c), 32'(ivc[i] + LAT));
            chk("instr_hold", rsq[i].ins, lw[i]);
        end
        chk("err_count", 32'(n_errp), 32'(qm.size() - lw.size()));
        chk("issued_count", 32'(issued_count), 32'(lw.size() % 256));
        chk("busy_after", 32'(busy), 32'd0);
        if (rsq.size() > 0) begin
            chk("res_out_hold", 32'(res_out), 32'(rsq[rsq.size()-1].out));
            chk("res_tag_hold", 32'(res_tag), 32'(rsq[rsq.size()-1].tag));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_outs"}, 32'({instr_valid, res_valid, err, done, busy}), 32'd0);
        chk({tag, "_res_out"}, 32'(res_out), 32'd0);
        chk({tag, "_res_tag"}, 32'(res_tag), 32'd0);
        chk({tag, "_count"}, 32'(issued_count), 32'd0);
        chk({tag, "_load_full"}, 32'(load_full), 32'd0);
    endtask

    initial begin
        logic [31:0] ws[$];
        logic [31:0] qm[$];
        rst = 1'b1; load_en = 1'b0; start = 1'b0; load_instr = '0; res_in = '0;
        clear_logs();
        repeat (2) step();
        chk_zero("reset");
        rst = 1'b0;
        step();

        run_seq('{{8'd0, 8'd3, 8'd57, 8'd100}, {8'd1, 8'd4, 8'd255, 8'd255}});
        if (rsq.size() >= 2) begin
            chk("basic_res0", 32'(rsq[0].out), 32'd32);
            chk("basic_res1", 32'(rsq[1].out), 32'd510);
        end

        ws.delete();
        for (int i = 0; i < 9; i++) ws.push_back({8'(i % 4), 8'(i + 10), 8'(i * 7), 8'(i * 3)});
        run_seq(ws);

        run_seq('{{8'd5, 8'd1, 8'd2, 8'd3}, {8'd1, 8'd2, 8'd1, 8'd1}});

        ws.delete();
        run_seq(ws);

        run_seq('{{8'd2, 8'd9, 8'd77, 8'd1}, {8'd3, 8'd10, 8'd5, 8'd6}});

        for (int r = 0; r < 8; r++) begin
            ws.delete();
            for (int i = 0; i < int'($urandom_range(0, DEPTH + 2)); i++) begin
                logic [7:0] op;
                op = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(4, 255));
                ws.push_back({op, 24'($urandom)});
            end
            run_seq(ws);
        end

        clear_logs();
        qm.delete();
        ws = '{{8'd1, 8'd21, 8'd1, 8'd2}, {8'd0, 8'd22, 8'd3, 8'd4}, {8'd1, 8'd23, 8'd5, 8'd6}};
        load_words(ws, qm);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 100 && ivq.size() < 2; k++) step();
        chk("rst_second_iv", 32'(ivq.size()), 32'd2);
        step();
        rst = 1'b1;
        step();
        chk_zero("midrst");
        rst = 1'b0;
        clear_logs();
        repeat (20) step();
        chk("midrst_no_res", 32'(rsq.size()), 32'd0);
        chk("midrst_no_done", 32'(n_done), 32'd0);
        ws.delete();
        run_seq(ws);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
